// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, functs,
// ALU codes, mux selects, FSM states and the control word.
package control_unit_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    // PC source select
    localparam logic [1:0] PCS_ALU     = 2'd0;
    localparam logic [1:0] PCS_ALU_REG = 2'd1;
    localparam logic [1:0] PCS_JUMP    = 2'd2;
    localparam logic [1:0] PCS_EXC     = 2'd3;

    // Load data extension select
    localparam logic [2:0] RDS_WORD = 3'd0;
    localparam logic [2:0] RDS_BZX  = 3'd1;
    localparam logic [2:0] RDS_BSX  = 3'd2;
    localparam logic [2:0] RDS_HZX  = 3'd3;
    localparam logic [2:0] RDS_HSX  = 3'd4;

    // Write-back source select
    localparam logic [2:0] M2R_ALU_REG = 3'd0;
    localparam logic [2:0] M2R_INSTR   = 3'd1;
    localparam logic [2:0] M2R_EPC     = 3'd2;
    localparam logic [2:0] M2R_CAUSE   = 3'd3;
    localparam logic [2:0] M2R_LOAD    = 3'd4;
    localparam logic [2:0] M2R_PC      = 3'd5;

    // Destination register select
    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    // ALU operand selects
    localparam logic       SEL1_PC   = 1'b0;
    localparam logic       SEL1_REG1 = 1'b1;
    localparam logic [2:0] SEL2_REG2 = 3'd0;
    localparam logic [2:0] SEL2_FOUR = 3'd1;
    localparam logic [2:0] SEL2_IMM  = 3'd2;
    localparam logic [2:0] SEL2_IMM2 = 3'd3;
    localparam logic [2:0] SEL2_ZERO = 3'd4;

    // Immediate extension and exception cause
    localparam logic EXT_SIGN     = 1'b0;
    localparam logic EXT_ZERO     = 1'b1;
    localparam logic CAUSE_UNDEF  = 1'b0;
    localparam logic CAUSE_OVF    = 1'b1;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_EXC
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_en;
        logic       mem_write;
        logic       iord;
        logic       epc_en;
        logic       reg_ws;
        logic       cause_en;
        logic [1:0] pc_src;
        logic [2:0] reg_data_sel;
        logic [2:0] mem_to_reg;
        logic [1:0] reg_dest;
        logic       alu_sel1;
        logic [2:0] alu_sel2;
        logic       signext_sel;
        logic       cause_sel;
        alu_op_e    alu_control;
    } ctrl_t;

    // True for R-type functs the datapath can execute in R_EXEC
    function automatic logic is_rtype_alu(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
            FN_NOR, FN_SLT, FN_SLL, FN_SRL, FN_SRA: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // Load extension mode for each load opcode
    function automatic logic [2:0] load_ext(input logic [5:0] op);
        case (op)
            OP_LBU:  return RDS_BZX;
            OP_LB:   return RDS_BSX;
            OP_LHU:  return RDS_HZX;
            OP_LH:   return RDS_HSX;
            default: return RDS_WORD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave).
// Instruction fields and ALU flags flow in; strobes and selects flow out.
interface control_unit_if;
    import control_unit_pkg::*;

    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       ZF_OUT;
    logic       NF_OUT;
    logic       OF_OUT;
    logic       BF_OUT;

    logic       IR_WRITE;
    logic       PC_EN;
    logic       MEM_WRITE;
    logic       IorD;
    logic       EPC_EN;
    logic       REG_WS;
    logic       CAUSE_EN;
    logic [1:0] PC_SRC;
    logic [2:0] REG_DATA_SEL;
    logic [2:0] MEMtoREG;
    logic [1:0] Reg_Dest;
    logic       ALU_SEL1;
    logic [2:0] ALU_SEL2;
    logic       SIGNEXT_SEL;
    logic       CAUSE_SEL;
    logic [3:0] ALU_CONTROL;

    modport master (
        input  OPCODE, FUNCT, ZF_OUT, NF_OUT, OF_OUT, BF_OUT,
        output IR_WRITE, PC_EN, MEM_WRITE, IorD, EPC_EN, REG_WS,
        output CAUSE_EN, PC_SRC, REG_DATA_SEL, MEMtoREG, Reg_Dest,
        output ALU_SEL1, ALU_SEL2, SIGNEXT_SEL, CAUSE_SEL, ALU_CONTROL
    );

    modport slave (
        output OPCODE, FUNCT, ZF_OUT, NF_OUT, OF_OUT, BF_OUT,
        input  IR_WRITE, PC_EN, MEM_WRITE, IorD, EPC_EN, REG_WS,
        input  CAUSE_EN, PC_SRC, REG_DATA_SEL, MEMtoREG, Reg_Dest,
        input  ALU_SEL1, ALU_SEL2, SIGNEXT_SEL, CAUSE_SEL, ALU_CONTROL
    );

endinterface

// File: rtl/control_unit_alu_control_decoder.sv
// Maps OPCODE/FUNCT to the ALU operation used in R_EXEC and I_EXEC.
// Purely combinational; unknown encodings fall back to ADD.
module alu_control_decoder
    import control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    alu_ctrl
);

    // R-type uses FUNCT, immediates use OPCODE
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_ctrl = ALU_ADD;
                FN_SUB:  alu_ctrl = ALU_SUB;
                FN_AND:  alu_ctrl = ALU_AND;
                FN_OR:   alu_ctrl = ALU_OR;
                FN_XOR:  alu_ctrl = ALU_XOR;
                FN_NOR:  alu_ctrl = ALU_NOR;
                FN_SLT:  alu_ctrl = ALU_SLT;
                FN_SLL:  alu_ctrl = ALU_SLL;
                FN_SRL:  alu_ctrl = ALU_SRL;
                FN_SRA:  alu_ctrl = ALU_SRA;
                default: alu_ctrl = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ADDI: alu_ctrl = ALU_ADD;
                OP_ANDI: alu_ctrl = ALU_AND;
                OP_ORI:  alu_ctrl = ALU_OR;
                OP_XORI: alu_ctrl = ALU_XOR;
                OP_SLTI: alu_ctrl = ALU_SLT;
                OP_LUI:  alu_ctrl = ALU_LUI;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS-style control FSM. Outputs are a function of the
// state and instruction fields, plus ZF_OUT for the branch PC enable.
module control_unit
    import control_unit_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    control_unit_if.master  bus
);

    state_t  state_q, state_d;
    logic    cause_q, cause_d;
    ctrl_t   ctrl;
    alu_op_e dec_alu;
    logic    unused_flags;

    // Negative and borrow flags have no consumer in this revision
    assign unused_flags = bus.NF_OUT ^ bus.BF_OUT;

    alu_control_decoder u_alu_dec (
        .opcode   (bus.OPCODE),
        .funct    (bus.FUNCT),
        .alu_ctrl (dec_alu)
    );

    // State and latched exception cause; reset aborts any instruction
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_INIT;
            cause_q <= CAUSE_UNDEF;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and control word for the current state
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ctrl.iord        = 1'b0;
                ctrl.ir_write    = 1'b1;
                ctrl.alu_sel1    = SEL1_PC;
                ctrl.alu_sel2    = SEL2_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_src      = PCS_ALU;
                ctrl.pc_en       = 1'b1;
                state_d          = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_sel1    = SEL1_PC;
                ctrl.alu_sel2    = SEL2_IMM2;
                ctrl.signext_sel = EXT_SIGN;
                ctrl.alu_control = ALU_ADD;
                case (bus.OPCODE)
                    OP_LW, OP_LB, OP_LBU,
                    OP_LH, OP_LHU, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (bus.FUNCT == FN_JR) begin
                            state_d = S_JR;
                        end else if (is_rtype_alu(bus.FUNCT)) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_EXC;
                            cause_d = CAUSE_UNDEF;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI, OP_LUI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_JAL:                   state_d = S_JAL;
                    default: begin
                        state_d = S_EXC;
                        cause_d = CAUSE_UNDEF;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_sel1    = SEL1_REG1;
                ctrl.alu_sel2    = SEL2_IMM;
                ctrl.signext_sel = EXT_SIGN;
                ctrl.alu_control = ALU_ADD;
                state_d = (bus.OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_ws       = 1'b1;
                ctrl.reg_dest     = RD_RT;
                ctrl.mem_to_reg   = M2R_LOAD;
                ctrl.reg_data_sel = load_ext(bus.OPCODE);
                state_d           = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_R_EXEC: begin
                ctrl.alu_sel1    = SEL1_REG1;
                ctrl.alu_sel2    = SEL2_REG2;
                ctrl.alu_control = dec_alu;
                if ((bus.FUNCT == FN_ADD || bus.FUNCT == FN_SUB)
                    && bus.OF_OUT) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                ctrl.reg_ws     = 1'b1;
                ctrl.reg_dest   = RD_RD;
                ctrl.mem_to_reg = M2R_ALU_REG;
                state_d         = S_FETCH;
            end
            S_I_EXEC: begin
                ctrl.alu_sel1    = SEL1_REG1;
                ctrl.alu_sel2    = SEL2_IMM;
                ctrl.alu_control = dec_alu;
                case (bus.OPCODE)
                    OP_ANDI, OP_ORI, OP_XORI: ctrl.signext_sel = EXT_ZERO;
                    default:                  ctrl.signext_sel = EXT_SIGN;
                endcase
                if (bus.OPCODE == OP_ADDI && bus.OF_OUT) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_I_WB;
                end
            end
            S_I_WB: begin
                ctrl.reg_ws     = 1'b1;
                ctrl.reg_dest   = RD_RT;
                ctrl.mem_to_reg = M2R_ALU_REG;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_sel1    = SEL1_REG1;
                ctrl.alu_sel2    = SEL2_REG2;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_src      = PCS_ALU_REG;
                ctrl.pc_en       = (bus.OPCODE == OP_BNE) ? !bus.ZF_OUT
                                                          : bus.ZF_OUT;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src = PCS_JUMP;
                ctrl.pc_en  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                ctrl.pc_src     = PCS_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.reg_ws     = 1'b1;
                ctrl.reg_dest   = RD_R31;
                ctrl.mem_to_reg = M2R_PC;
                state_d         = S_FETCH;
            end
            S_JR: begin
                ctrl.alu_sel1    = SEL1_REG1;
                ctrl.alu_sel2    = SEL2_ZERO;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_src      = PCS_ALU;
                ctrl.pc_en       = 1'b1;
                state_d          = S_FETCH;
            end
            S_EXC: begin
                // PC already advanced by 4; subtract to recover faulting PC
                ctrl.cause_en    = 1'b1;
                ctrl.cause_sel   = cause_q;
                ctrl.epc_en      = 1'b1;
                ctrl.alu_sel1    = SEL1_PC;
                ctrl.alu_sel2    = SEL2_FOUR;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_src      = PCS_EXC;
                ctrl.pc_en       = 1'b1;
                state_d          = S_FETCH;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign bus.IR_WRITE     = ctrl.ir_write;
    assign bus.PC_EN        = ctrl.pc_en;
    assign bus.MEM_WRITE    = ctrl.mem_write;
    assign bus.IorD         = ctrl.iord;
    assign bus.EPC_EN       = ctrl.epc_en;
    assign bus.REG_WS       = ctrl.reg_ws;
    assign bus.CAUSE_EN     = ctrl.cause_en;
    assign bus.PC_SRC       = ctrl.pc_src;
    assign bus.REG_DATA_SEL = ctrl.reg_data_sel;
    assign bus.MEMtoREG     = ctrl.mem_to_reg;
    assign bus.Reg_Dest     = ctrl.reg_dest;
    assign bus.ALU_SEL1     = ctrl.alu_sel1;
    assign bus.ALU_SEL2     = ctrl.alu_sel2;
    assign bus.SIGNEXT_SEL  = ctrl.signext_sel;
    assign bus.CAUSE_SEL    = ctrl.cause_sel;
    assign bus.ALU_CONTROL  = ctrl.alu_control;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class
// cycle by cycle and compares state plus the full control word.
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    control_unit_if cu_if ();

    control_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (cu_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] outs();
        return {cu_if.IR_WRITE, cu_if.PC_EN, cu_if.MEM_WRITE, cu_if.IorD,
                cu_if.EPC_EN, cu_if.REG_WS, cu_if.CAUSE_EN, cu_if.PC_SRC,
                cu_if.REG_DATA_SEL, cu_if.MEMtoREG, cu_if.Reg_Dest,
                cu_if.ALU_SEL1, cu_if.ALU_SEL2, cu_if.SIGNEXT_SEL,
                cu_if.CAUSE_SEL, cu_if.ALU_CONTROL};
    endfunction

    function automatic logic [26:0] mk(
        input logic ir, input logic pcen, input logic mw, input logic iord,
        input logic epc, input logic rws, input logic cen,
        input logic [1:0] pcs, input logic [2:0] rds, input logic [2:0] m2r,
        input logic [1:0] rd, input logic s1, input logic [2:0] s2,
        input logic sx, input logic cs, input logic [3:0] alu);
        return {ir, pcen, mw, iord, epc, rws, cen, pcs, rds, m2r, rd,
                s1, s2, sx, cs, alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state and control word for this cycle, then advance
    task automatic see(input string tag, input state_t s,
                       input logic [26:0] o);
        check({tag, ".st"}, 32'(dut.state_q), 32'(s));
        check(tag, 32'(outs()), 32'(o));
        tick();
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zf, input logic of);
        cu_if.OPCODE = op;
        cu_if.FUNCT  = fn;
        cu_if.ZF_OUT = zf;
        cu_if.OF_OUT = of;
    endtask

    // Hand-derived control words
    logic [26:0] w_zero, w_f, w_d, w_rx_add, w_rx_sub, w_rwb, w_ma, w_mr;
    logic [26:0] w_wb_lb, w_mw, w_br_t, w_br_n, w_ix_addi, w_ix_ori, w_iwb;
    logic [26:0] w_exc_ovf, w_exc_und, w_jal, w_jr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        w_zero    = 27'd0;
        w_f       = mk(1,1,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b0,3'd1,0,0, 4'd0);
        w_d       = mk(0,0,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b0,3'd3,0,0, 4'd0);
        w_rx_add  = mk(0,0,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b1,3'd0,0,0, 4'd0);
        w_rx_sub  = mk(0,0,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b1,3'd0,0,0, 4'd1);
        w_rwb     = mk(0,0,0,0,0,1,0, 2'd0,3'd0,3'd0,2'd1, 1'b0,3'd0,0,0, 4'd0);
        w_ma      = mk(0,0,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b1,3'd2,0,0, 4'd0);
        w_mr      = mk(0,0,0,1,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b0,3'd0,0,0, 4'd0);
        w_wb_lb   = mk(0,0,0,0,0,1,0, 2'd0,3'd2,3'd4,2'd0, 1'b0,3'd0,0,0, 4'd0);
        w_mw      = mk(0,0,1,1,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b0,3'd0,0,0, 4'd0);
        w_br_t    = mk(0,1,0,0,0,0,0, 2'd1,3'd0,3'd0,2'd0, 1'b1,3'd0,0,0, 4'd1);
        w_br_n    = mk(0,0,0,0,0,0,0, 2'd1,3'd0,3'd0,2'd0, 1'b1,3'd0,0,0, 4'd1);
        w_ix_addi = mk(0,0,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b1,3'd2,0,0, 4'd0);
        w_ix_ori  = mk(0,0,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b1,3'd2,1,0, 4'd3);
        w_iwb     = mk(0,0,0,0,0,1,0, 2'd0,3'd0,3'd0,2'd0, 1'b0,3'd0,0,0, 4'd0);
        w_exc_ovf = mk(0,1,0,0,1,0,1, 2'd3,3'd0,3'd0,2'd0, 1'b0,3'd1,0,1, 4'd1);
        w_exc_und = mk(0,1,0,0,1,0,1, 2'd3,3'd0,3'd0,2'd0, 1'b0,3'd1,0,0, 4'd1);
        w_jal     = mk(0,1,0,0,0,1,0, 2'd2,3'd0,3'd5,2'd2, 1'b0,3'd0,0,0, 4'd0);
        w_jr      = mk(0,1,0,0,0,0,0, 2'd0,3'd0,3'd0,2'd0, 1'b1,3'd4,0,0, 4'd0);

        rst = 1'b1;
        cu_if.NF_OUT = 1'b0;
        cu_if.BF_OUT = 1'b0;
        set_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // add rd
        see("rst.init", S_INIT, w_zero);
        see("add.f", S_FETCH, w_f);
        see("add.d", S_DECODE, w_d);
        see("add.x", S_R_EXEC, w_rx_add);
        see("add.wb", S_R_WB, w_rwb);

        // lb: five cycles
        set_instr(OP_LB, 6'h00, 1'b0, 1'b0);
        see("lb.f", S_FETCH, w_f);
        see("lb.d", S_DECODE, w_d);
        see("lb.ma", S_MEM_ADDR, w_ma);
        see("lb.mr", S_MEM_RD, w_mr);
        see("lb.wb", S_MEM_WB, w_wb_lb);

        // sw: four cycles
        set_instr(OP_SW, 6'h00, 1'b0, 1'b0);
        see("sw.f", S_FETCH, w_f);
        see("sw.d", S_DECODE, w_d);
        see("sw.ma", S_MEM_ADDR, w_ma);
        see("sw.mw", S_MEM_WR, w_mw);

        // branches, taken and not taken
        set_instr(OP_BEQ, 6'h00, 1'b1, 1'b0);
        see("beq1.f", S_FETCH, w_f);
        see("beq1.d", S_DECODE, w_d);
        see("beq1.br", S_BRANCH, w_br_t);
        set_instr(OP_BEQ, 6'h00, 1'b0, 1'b0);
        see("beq0.f", S_FETCH, w_f);
        see("beq0.d", S_DECODE, w_d);
        see("beq0.br", S_BRANCH, w_br_n);
        set_instr(OP_BNE, 6'h00, 1'b0, 1'b0);
        see("bne0.f", S_FETCH, w_f);
        see("bne0.d", S_DECODE, w_d);
        see("bne0.br", S_BRANCH, w_br_t);
        set_instr(OP_BNE, 6'h00, 1'b1, 1'b0);
        see("bne1.f", S_FETCH, w_f);
        see("bne1.d", S_DECODE, w_d);
        see("bne1.br", S_BRANCH, w_br_n);

        // addi overflow: no write-back
        set_instr(OP_ADDI, 6'h00, 1'b0, 1'b1);
        see("addio.f", S_FETCH, w_f);
        see("addio.d", S_DECODE, w_d);
        see("addio.x", S_I_EXEC, w_ix_addi);
        see("addio.exc", S_EXC, w_exc_ovf);

        // ori: zero-extended immediate, normal write-back
        set_instr(OP_ORI, 6'h00, 1'b0, 1'b1);
        see("ori.f", S_FETCH, w_f);
        see("ori.d", S_DECODE, w_d);
        see("ori.x", S_I_EXEC, w_ix_ori);
        see("ori.wb", S_I_WB, w_iwb);

        // sub overflow
        set_instr(OP_RTYPE, FN_SUB, 1'b0, 1'b1);
        see("subo.f", S_FETCH, w_f);
        see("subo.d", S_DECODE, w_d);
        see("subo.x", S_R_EXEC, w_rx_sub);
        see("subo.exc", S_EXC, w_exc_ovf);

        // jal and jr
        set_instr(OP_JAL, 6'h00, 1'b0, 1'b0);
        see("jal.f", S_FETCH, w_f);
        see("jal.d", S_DECODE, w_d);
        see("jal.j", S_JAL, w_jal);
        set_instr(OP_RTYPE, FN_JR, 1'b0, 1'b0);
        see("jr.f", S_FETCH, w_f);
        see("jr.d", S_DECODE, w_d);
        see("jr.j", S_JR, w_jr);

        // undefined opcode after an overflow: cause must return to 0
        set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
        see("und.f", S_FETCH, w_f);
        see("und.d", S_DECODE, w_d);
        see("und.exc", S_EXC, w_exc_und);

        // reset pulsed mid-load
        set_instr(OP_LW, 6'h00, 1'b0, 1'b0);
        see("lwr.f", S_FETCH, w_f);
        see("lwr.d", S_DECODE, w_d);
        see("lwr.ma", S_MEM_ADDR, w_ma);
        check("lwr.mr.st", 32'(dut.state_q), 32'(S_MEM_RD));
        check("lwr.mr", 32'(outs()), 32'(w_mr));
        #2;
        rst = 1'b1;
        #1;
        check("arst.st", 32'(dut.state_q), 32'(S_INIT));
        check("arst.o", 32'(outs()), 32'(w_zero));
        tick();
        rst = 1'b0;
        see("arst.init", S_INIT, w_zero);
        see("arst.f", S_FETCH, w_f);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all widths fixed by the 32-bit multicycle datapath.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 OPCODE  in  6  Instr[31:26] from the instruction register.
REQ-005 FUNCT  in  6  Instr[5:0].
REQ-006 ZF_OUT, NF_OUT, OF_OUT, BF_OUT  in  1 each  ALU flags (zero, negative, overflow, borrow); NF_OUT and BF_OUT are unused in this revision.
REQ-007 IR_WRITE, PC_EN, MEM_WRITE, IorD, EPC_EN, REG_WS, CAUSE_EN  out  1 each  load/write strobes; IorD selects the memory address (0 PC, 1 ALU_REG_OUT).
REQ-008 PC_SRC  out  2  PC source: 0 ALU_OUT, 1 ALU_REG_OUT, 2 jump target, 3 exception vector.
REQ-009 REG_DATA_SEL  out  3  load extension: 0 word, 1 byte zero-extended, 2 byte sign-extended, 3 half zero-extended, 4 half sign-extended.
REQ-010 MEMtoREG  out  3  write-back source: 0 ALU_REG_OUT, 1 Instr, 2 EPC, 3 CAUSE, 4 load data, 5 PC.
REQ-011 Reg_Dest  out  2  write register: 0 rt, 1 rd, 2 r31.
REQ-012 ALU_SEL1  out  1  operand 1: 0 PC, 1 Reg1.
REQ-013 ALU_SEL2  out  3  operand 2: 0 Reg2, 1 constant 4, 2 immediate, 3 immediate<<2, 4 zero.
REQ-014 SIGNEXT_SEL, CAUSE_SEL  out  1 each  immediate extension (0 sign, 1 zero); exception cause (0 undefined opcode, 1 overflow).
REQ-015 ALU_CONTROL  out  4  ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLL 7, SRL 8, SRA 9, LUI 10.

Function
REQ-016 FSM states: INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, EXC.
REQ-017 Any output not listed for a state is 0; outputs depend on state, OPCODE and FUNCT only, except the BRANCH PC_EN (REQ-021).
REQ-018 INIT: all outputs 0; next state is FETCH unconditionally.
REQ-019 FETCH: IorD=0, IR_WRITE=1, ALU_SEL1=0, ALU_SEL2=1, ADD, PC_SRC=0, PC_EN=1; next state DECODE.
REQ-020 DECODE: ALU_SEL1=0, ALU_SEL2=3, SIGNEXT_SEL=0, ADD (precomputes the branch target). Dispatch by opcode:
- lw/lb/lbu/lh/lhu/sw -> MEM_ADDR
- R-type -> R_EXEC, or JR when FUNCT=jr
- addi/andi/ori/xori/slti/lui -> I_EXEC
- beq/bne -> BRANCH
- j -> JUMP; jal -> JAL
- anything else, or an unknown R-type funct -> EXC with CAUSE_SEL=0
REQ-021 BRANCH: ALU_SEL1=1, ALU_SEL2=0, SUB, PC_SRC=1; PC_EN=ZF_OUT for beq and !ZF_OUT for bne; next state FETCH. Total 3 cycles.
REQ-022 JUMP: PC_SRC=2, PC_EN=1; next FETCH. JAL: adds REG_WS=1, Reg_Dest=2, MEMtoREG=5; next FETCH. JR: ALU_SEL1=1, ALU_SEL2=4, ADD, PC_SRC=0, PC_EN=1; next FETCH.
REQ-023 MEM_ADDR: ALU_SEL1=1, ALU_SEL2=2, SIGNEXT_SEL=0, ADD; next MEM_WR for sw, otherwise MEM_RD.
REQ-024 MEM_RD: IorD=1; next MEM_WB. MEM_WB: REG_WS=1, Reg_Dest=0, MEMtoREG=4, REG_DATA_SEL set per opcode; next FETCH. Load is 5 cycles.
REQ-025 MEM_WR: IorD=1, MEM_WRITE=1; next FETCH. Store is 4 cycles.
REQ-026 R_EXEC: ALU_SEL1=1, ALU_SEL2=0, ALU_CONTROL from FUNCT.
- If add/sub and OF_OUT=1: next EXC with CAUSE_SEL=1.
- Otherwise: next R_WB.
REQ-027 R_WB: REG_WS=1, Reg_Dest=1, MEMtoREG=0; next FETCH.
REQ-028 I_EXEC: ALU_SEL1=1, ALU_SEL2=2, ALU_CONTROL from OPCODE; SIGNEXT_SEL=1 for andi/ori/xori.
- If addi and OF_OUT=1: next EXC with CAUSE_SEL=1.
- Otherwise: next I_WB.
REQ-029 I_WB: REG_WS=1, Reg_Dest=0, MEMtoREG=0; next FETCH.
REQ-030 EXC: CAUSE_EN=1, CAUSE_SEL held from the entering transition, EPC_EN=1 with ALU_SEL1=0, ALU_SEL2=1, SUB (EPC = faulting PC); PC_SRC=3, PC_EN=1; REG_WS=0; next FETCH.
REQ-031 An overflow exception suppresses the write-back; the destination register is unchanged.

Reset
REQ-032 RST asserted drives the state to INIT immediately (asynchronously), forcing every output to 0. This holds mid-instruction, so no partial write or PC update occurs.
REQ-033 The first FETCH occurs in the second rising edge's cycle after RST deasserts.

Structure
REQ-034 Shared package holds the opcode/funct constants, the ALU_CONTROL codes, all mux-select encodings and the state enumeration.
REQ-035 Sub-module alu_control_decoder maps OPCODE/FUNCT to ALU_CONTROL for R_EXEC/I_EXEC; it is combinational and is instantiated once.

Verification
REQ-036 Reset then add (rd=3): INIT, FETCH, DECODE, R_EXEC, R_WB; REG_WS=1 only in R_WB with Reg_Dest=1, ALU_CONTROL=0 in R_EXEC.
REQ-037 lb: 5-cycle sequence; MEM_WB shows REG_DATA_SEL=2, MEMtoREG=4; sw reaches MEM_WR with MEM_WRITE=1 and IorD=1 in cycle 4.
REQ-038 beq with ZF_OUT=1 -> PC_EN=1, PC_SRC=1 in BRANCH; ZF_OUT=0 -> PC_EN=0; bne is the inverse.
REQ-039 addi with OF_OUT=1 in I_EXEC -> EXC next, CAUSE_EN=1, CAUSE_SEL=1, EPC_EN=1, PC_SRC=3, and REG_WS never asserted.
REQ-040 Opcode 6'h3F -> EXC after DECODE with CAUSE_SEL=0; RST pulsed during MEM_RD -> outputs 0 at once, then INIT, then FETCH.
